// File: rtl/smem_pkg.sv
// Shared widths, tag kind codes and issue-FSM encoding for the BWT memory
// request issuer and its request FIFO.
package smem_pkg;

    localparam int ADDR_W = 42;
    localparam int RN_W   = 10;
    localparam int TAG_W  = RN_W + 2;
    localparam int REQ_W  = RN_W + 2 * ADDR_W;

    localparam logic [1:0] KIND_K  = 2'b01;
    localparam logic [1:0] KIND_L  = 2'b10;
    localparam logic [1:0] KIND_KL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE_K = 2'd1,
        ST_ISSUE_L = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [RN_W-1:0]   read_num;
        logic [ADDR_W-1:0] addr_k;
        logic [ADDR_W-1:0] addr_l;
    } mem_req_t;

    // First transaction kind of an entry: both halves collapse into one when k and l share a line.
    function automatic logic [1:0] first_kind(input logic [ADDR_W-1:0] k, input logic [ADDR_W-1:0] l);
        logic [1:0] kind;
        if (k == l) begin
            kind = KIND_KL;
        end else begin
            kind = KIND_K;
        end
        return kind;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Request buffer: DEPTH x WIDTH FIFO with extra-MSB pointers so full/empty are
// distinguished without a separate flag; exposes the head and the entry behind it.
module mem_req_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 94
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [WIDTH-1:0]         next_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [PW-1:0]    rd_ptr_inc_s;
    logic             wr_fire_s;
    logic             rd_fire_s;

    assign empty_o      = (wr_ptr_q == rd_ptr_q);
    assign full_o       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o      = wr_ptr_q - rd_ptr_q;
    assign rd_ptr_inc_s = rd_ptr_q + PW'(1);
    assign head_o       = mem_q[rd_ptr_q[AW-1:0]];
    assign next_o       = mem_q[rd_ptr_inc_s[AW-1:0]];
    assign wr_fire_s    = wr_en_i & ~full_o;
    assign rd_fire_s    = rd_en_i & ~empty_o;

    // Pointer advance, guarded against overflow and underflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_inc_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (wr_fire_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/bwt_mem_req_issuer.sv
// Buffers occurrence-table requests from the backward pipeline and issues each as one
// (merged) or two (k then l) valid/ready memory transactions; stalls upstream near full.
module bwt_mem_req_issuer #(
    parameter int DEPTH        = 16,
    parameter int STALL_MARGIN = 1,
    parameter int ADDR_W       = smem_pkg::ADDR_W,
    parameter int RN_W         = smem_pkg::RN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     request_valid,
    input  logic [ADDR_W-1:0]        addr_k,
    input  logic [ADDR_W-1:0]        addr_l,
    input  logic [RN_W-1:0]          read_num,
    output logic                     stall,
    output logic                     mem_req_valid,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic [RN_W+1:0]          mem_req_tag,
    input  logic                     mem_req_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [31:0]              req_issued
);

    import smem_pkg::KIND_K;
    import smem_pkg::KIND_L;
    import smem_pkg::KIND_KL;
    import smem_pkg::issue_state_e;
    import smem_pkg::ST_IDLE;
    import smem_pkg::ST_ISSUE_K;
    import smem_pkg::ST_ISSUE_L;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = RN_W + 2 * ADDR_W;
    localparam int TAG_W = RN_W + 2;
    localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(DEPTH - STALL_MARGIN);

    issue_state_e      state_q;
    issue_state_e      state_d;
    logic              valid_q;
    logic              valid_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  tag_d;
    logic              stall_q;
    logic              stall_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [31:0]       issued_q;
    logic [31:0]       issued_d;

    logic              enq_s;
    logic              pop_s;
    logic              handshake_s;
    logic              more_s;
    logic [ENT_W-1:0]  head_s;
    logic [ENT_W-1:0]  next_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    logic [RN_W-1:0]   head_rn_s;
    logic [ADDR_W-1:0] head_k_s;
    logic [ADDR_W-1:0] head_l_s;
    logic [1:0]        head_kind_s;
    logic [RN_W-1:0]   next_rn_s;
    logic [ADDR_W-1:0] next_k_s;
    logic [ADDR_W-1:0] next_l_s;
    logic [1:0]        next_kind_s;

    assign enq_s       = request_valid & ~stall_q;
    assign handshake_s = valid_q & mem_req_ready;
    assign more_s      = (fifo_count_s > CNT_W'(1));

    assign head_rn_s   = head_s[ENT_W-1 -: RN_W];
    assign head_k_s    = head_s[2*ADDR_W-1 -: ADDR_W];
    assign head_l_s    = head_s[ADDR_W-1:0];
    assign head_kind_s = (head_k_s == head_l_s) ? KIND_KL : KIND_K;
    assign next_rn_s   = next_s[ENT_W-1 -: RN_W];
    assign next_k_s    = next_s[2*ADDR_W-1 -: ADDR_W];
    assign next_l_s    = next_s[ADDR_W-1:0];
    assign next_kind_s = (next_k_s == next_l_s) ? KIND_KL : KIND_K;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk_i     (clk),
        .rst_ni    (rst),
        .wr_en_i   (enq_s),
        .wr_data_i ({read_num, addr_k, addr_l}),
        .rd_en_i   (pop_s),
        .head_o    (head_s),
        .next_o    (next_s),
        .count_o   (fifo_count_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s)
    );

    // Issue FSM: the entry is popped only on its final transaction; a pop with another entry
    // already stored reloads ISSUE_K straight from the entry behind the head.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_ISSUE_K;
                    valid_d = 1'b1;
                    addr_d  = head_k_s;
                    tag_d   = {head_rn_s, head_kind_s};
                end else begin
                    valid_d = 1'b0;
                    addr_d  = '0;
                    tag_d   = '0;
                end
            end
            ST_ISSUE_K: begin
                if (handshake_s && (tag_q[1:0] == KIND_KL)) begin
                    pop_s = 1'b1;
                    if (more_s) begin
                        state_d = ST_ISSUE_K;
                        addr_d  = next_k_s;
                        tag_d   = {next_rn_s, next_kind_s};
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        addr_d  = '0;
                        tag_d   = '0;
                    end
                end else if (handshake_s) begin
                    state_d = ST_ISSUE_L;
                    addr_d  = head_l_s;
                    tag_d   = {head_rn_s, KIND_L};
                end else begin
                    state_d = ST_ISSUE_K;
                end
            end
            ST_ISSUE_L: begin
                if (handshake_s) begin
                    pop_s = 1'b1;
                    if (more_s) begin
                        state_d = ST_ISSUE_K;
                        addr_d  = next_k_s;
                        tag_d   = {next_rn_s, next_kind_s};
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        addr_d  = '0;
                        tag_d   = '0;
                    end
                end else begin
                    state_d = ST_ISSUE_L;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                addr_d  = '0;
                tag_d   = '0;
            end
        endcase
    end

    // Occupancy, stall threshold and saturating transaction counter.
    always_comb begin
        count_d  = fifo_count_s + CNT_W'(enq_s) - CNT_W'(pop_s);
        stall_d  = (count_d >= STALL_LEVEL);
        issued_d = issued_q;
        if (handshake_s && (issued_q != 32'hFFFF_FFFF)) begin
            issued_d = issued_q + 32'd1;
        end else begin
            issued_d = issued_q;
        end
    end

    // All externally visible state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            tag_q    <= '0;
            stall_q  <= 1'b0;
            count_q  <= '0;
            issued_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            stall_q  <= stall_d;
            count_q  <= count_d;
            issued_q <= issued_d;
        end
    end

    assign stall         = stall_q;
    assign mem_req_valid = valid_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_tag   = tag_q;
    assign fifo_count    = count_q;
    assign req_issued    = issued_q;

    logic unused_s;
    assign unused_s = fifo_full_s;

endmodule

// File: tb/tb_bwt_mem_req_issuer.sv
// Scoreboard bench for bwt_mem_req_issuer: stimulus pushes expected transactions,
// a negedge monitor pops and compares on every handshake.
module tb_bwt_mem_req_issuer;
    import smem_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 42;
    localparam int RW    = 10;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          request_valid;
    logic [AW-1:0] addr_k;
    logic [AW-1:0] addr_l;
    logic [RW-1:0] read_num;
    logic          stall;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic [RW+1:0] mem_req_tag;
    logic          mem_req_ready;
    logic [CW-1:0] fifo_count;
    logic [31:0]   req_issued;

    bwt_mem_req_issuer #(.DEPTH(16), .STALL_MARGIN(1), .ADDR_W(AW), .RN_W(RW)) dut (
        .clk(clk), .rst(rst), .request_valid(request_valid), .addr_k(addr_k), .addr_l(addr_l),
        .read_num(read_num), .stall(stall), .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
        .fifo_count(fifo_count), .req_issued(req_issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW+1:0] tag;
        bit            last;
    } txn_t;

    txn_t    exp_q[$];
    int      exp_count = 0;
    longint  exp_issued = 0;
    int      vectors = 0;
    int      miscompares = 0;
    int      ready_mode = 0;
    logic    ready_hold = 1'b0;
    logic          hold_pend = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [RW+1:0] hold_tag;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // Ready generator: held level, alternating, or 50% random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       mem_req_ready = ready_hold;
            1:       mem_req_ready = ~mem_req_ready;
            default: mem_req_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: checks occupancy/stall/counter, holds across backpressure, and pops the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            hold_pend = 1'b0;
        end else begin
            check("fifo_count", 64'(fifo_count), 64'(exp_count));
            check("stall", 64'(stall), 64'(exp_count >= DEPTH - 1));
            check("req_issued", 64'(req_issued), 64'(exp_issued));
            if (hold_pend) begin
                check("hold_valid", 64'(mem_req_valid), 64'(1));
                check("hold_addr", 64'(mem_req_addr), 64'(hold_addr));
                check("hold_tag", 64'(mem_req_tag), 64'(hold_tag));
            end
            hold_pend = mem_req_valid && !mem_req_ready;
            hold_addr = mem_req_addr;
            hold_tag  = mem_req_tag;
            if (request_valid && !stall) begin
                check("enq_room", 64'(exp_count < DEPTH), 64'(1));
                if (addr_k == addr_l) begin
                    exp_q.push_back('{addr: addr_k, tag: {read_num, KIND_KL}, last: 1'b1});
                end else begin
                    exp_q.push_back('{addr: addr_k, tag: {read_num, KIND_K}, last: 1'b0});
                    exp_q.push_back('{addr: addr_l, tag: {read_num, KIND_L}, last: 1'b1});
                end
                exp_count++;
            end
            if (mem_req_valid && mem_req_ready) begin
                check("txn_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    txn_t t;
                    t = exp_q.pop_front();
                    check("txn_addr", 64'(mem_req_addr), 64'(t.addr));
                    check("txn_tag", 64'(mem_req_tag), 64'(t.tag));
                    if (t.last) exp_count--;
                end
                exp_issued++;
            end
        end
    end

    task automatic send(input logic [RW-1:0] rn, input logic [AW-1:0] k, input logic [AW-1:0] l);
        int waited = 0;
        bit acc = 1'b0;
        request_valid = 1'b1;
        read_num = rn;
        addr_k = k;
        addr_l = l;
        while (!acc && waited < 2000) begin
            @(negedge clk);
            acc = !stall;
            @(posedge clk);
            #1;
            waited++;
        end
        request_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: request %0d not accepted, expected acceptance", rn);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || mem_req_valid) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        if (n >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d transactions outstanding, expected 0", exp_q.size());
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[AW-1:0];
    endfunction

    task automatic send_random(input int merge_pct);
        logic [AW-1:0] k;
        logic [AW-1:0] l;
        k = rand_addr();
        l = ($urandom_range(0, 99) < merge_pct) ? k : (k ^ 42'h1);
        send(RW'($urandom_range(0, 1023)), k, l);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, 64'(stall), 64'(0));
        check({tag, "_valid"}, 64'(mem_req_valid), 64'(0));
        check({tag, "_addr"}, 64'(mem_req_addr), 64'(0));
        check({tag, "_tag"}, 64'(mem_req_tag), 64'(0));
        check({tag, "_count"}, 64'(fifo_count), 64'(0));
        check({tag, "_issued"}, 64'(req_issued), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        request_valid = 1'b0;
        addr_k = '0;
        addr_l = '0;
        read_num = '0;
        mem_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset");
        ready_hold = 1'b1;
        #19 rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: split request, latency from empty
        send(RW'(5), 42'h100, 42'h101);
        @(negedge clk);
        check("latency_n1_valid", 64'(mem_req_valid), 64'(0));
        @(negedge clk);
        check("latency_n2_valid", 64'(mem_req_valid), 64'(1));
        check("latency_n2_addr", 64'(mem_req_addr), 64'(42'h100));
        @(posedge clk);
        #1;
        drain();
        check("t1_issued", 64'(req_issued), 64'(2));

        // 2: merged request
        send(RW'(7), 42'h2A0, 42'h2A0);
        drain();
        check("t2_issued", 64'(req_issued), 64'(3));
        check("t2_count", 64'(fifo_count), 64'(0));

        // 3: backpressure and stall threshold
        ready_hold = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 20; i++) begin
            send(RW'(100 + i), rand_addr() & ~42'h1, 42'h0);
            if (i == 14) check("t3_stall_at14", 64'(stall), 64'(0));
            if (i == 15) begin
                check("t3_stall_at15", 64'(stall), 64'(1));
                check("t3_count_at15", 64'(fifo_count), 64'(15));
                ready_hold = 1'b1;
            end
        end
        drain();
        check("t3_issued", 64'(req_issued), 64'(43));

        // 4: alternating ready
        ready_mode = 1;
        for (int i = 0; i < 12; i++) send_random(30);
        drain();

        // 5: wrap-around with random ready
        ready_mode = 2;
        for (int i = 0; i < 100; i++) begin
            send_random(25);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        check("t5_issued", 64'(req_issued), 64'(exp_issued));

        // 6: reset in ISSUE_L with entries queued
        ready_mode = 0;
        ready_hold = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(RW'(200 + i), 42'h400 + 42'(2 * i), 42'h800 + 42'(2 * i));
        @(negedge clk);
        #1;
        ready_hold = 1'b1;
        @(posedge clk);
        #2;
        ready_hold = 1'b0;
        @(posedge clk);
        #3;
        check("t6_pre_kind", 64'(mem_req_tag[1:0]), 64'(KIND_L));
        check("t6_pre_count", 64'(fifo_count), 64'(5));
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        exp_q.delete();
        exp_count = 0;
        exp_issued = 0;
        #20 rst = 1'b1;
        ready_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_idle_valid", 64'(mem_req_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        send(RW'(9), 42'h3C0, 42'h3C0);
        drain();
        check("t6_issued", 64'(req_issued), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
